// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the chunked sequential adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index register needs at least one bit even when there is a single chunk.
  function automatic int calc_idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/adder_nbit_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, carry rippled
// through a register, valid/ready handshakes on both sides.
module adder_nbit_seq
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready=1
  // BUSY  | adding one chunk per edge, LSB chunk first
  // DONE  | result held with out_valid=1 until out_ready

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = calc_idx_w(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("adder_nbit_seq: WIDTH must be >= 2 and divisible by CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic [IDXW-1:0]  idx;

  int               shamt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CHUNK-1:0] x;
  logic [CHUNK-1:0] y;
  logic [CHUNK-1:0] s;
  logic             co;
  logic [WIDTH-1:0] chunk_mask;
  logic [WIDTH-1:0] s_placed;
  logic [WIDTH-1:0] sum_next;

  // A single slice is shared across chunks; idx selects which bits feed it.
  assign shamt = int'(idx) * CHUNK;
  assign a_sh  = op_a >> shamt;
  assign b_sh  = op_b >> shamt;
  assign x     = a_sh[CHUNK-1:0];
  assign y     = b_sh[CHUNK-1:0];

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x  (x),
    .y  (y),
    .ci (cin),
    .s  (s),
    .co (co)
  );

  assign chunk_mask = WIDTH'({CHUNK{1'b1}}) << shamt;
  assign s_placed   = WIDTH'(s) << shamt;
  assign sum_next   = (sum & ~chunk_mask) | s_placed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      cin       <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a     <= a;
            op_b     <= sub ? ~b : b;
            cin      <= sub;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          sum <= sum_next;
          cin <= co;
          if (idx == LAST_IDX) begin
            carry     <= co;
            // The final slice holds the result MSB, so s[CHUNK-1] is sum's MSB.
            overflow  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (s[CHUNK-1] != op_a[WIDTH-1]);
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_nbit_seq.sv
// Bench for adder_nbit_seq: directed cases, backpressure, async reset abort and
// a random sweep over several WIDTH/CHUNK configurations against an arithmetic model.
module tb_adder_nbit_seq;

  localparam int NDUT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic [NDUT-1:0] in_ready_w;
  logic [NDUT-1:0] out_valid_w;
  logic [NDUT-1:0] carry_w;
  logic [NDUT-1:0] ovf_w;
  logic [7:0]      sum8 [4];
  logic [15:0]     sum16;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] cap_sum [NDUT];
  logic        cap_c   [NDUT];
  logic        cap_v   [NDUT];
  int          lat     [NDUT];

  always #5 clk = ~clk;

  adder_nbit_seq #(.WIDTH(8), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .sum(sum8[0]), .carry(carry_w[0]), .overflow(ovf_w[0]));

  adder_nbit_seq #(.WIDTH(8), .CHUNK(1)) u_dut_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .sum(sum8[1]), .carry(carry_w[1]), .overflow(ovf_w[1]));

  adder_nbit_seq #(.WIDTH(8), .CHUNK(2)) u_dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .sum(sum8[2]), .carry(carry_w[2]), .overflow(ovf_w[2]));

  adder_nbit_seq #(.WIDTH(8), .CHUNK(8)) u_dut_c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[3]),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .out_valid(out_valid_w[3]), .out_ready(out_ready),
    .sum(sum8[3]), .carry(carry_w[3]), .overflow(ovf_w[3]));

  adder_nbit_seq #(.WIDTH(16), .CHUNK(4)) u_dut_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[4]),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid_w[4]), .out_ready(out_ready),
    .sum(sum16), .carry(carry_w[4]), .overflow(ovf_w[4]));

  function automatic int dut_w(input int i);
    return (i == 4) ? 16 : 8;
  endfunction

  function automatic int dut_n(input int i);
    case (i)
      0: return 2;
      1: return 8;
      2: return 4;
      3: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [15:0] get_sum(input int i);
    if (i < 4) return {8'h00, sum8[i[1:0]]};
    return sum16;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Plain integer arithmetic: modulo sum, unsigned borrow rule, signed range test.
  task automatic ref_model(input int w, input logic [15:0] ai, input logic [15:0] bi,
                           input logic si, output logic [15:0] s, output logic c,
                           output logic v);
    longint mask, ua, ub, sa, sb, r, sr, smax;
    mask = (longint'(1) << w) - 1;
    smax = (longint'(1) << (w - 1)) - 1;
    ua = longint'(ai) & mask;
    ub = longint'(bi) & mask;
    sa = (ua > smax) ? ua - (mask + 1) : ua;
    sb = (ub > smax) ? ub - (mask + 1) : ub;
    r  = si ? ua - ub : ua + ub;
    sr = si ? sa - sb : sa + sb;
    s  = 16'(r & mask);
    c  = si ? (ua >= ub) : (r > mask);
    v  = (sr > smax) || (sr < -smax - 1);
  endtask

  task automatic wait_all_ready();
    int k;
    k = 0;
    while (in_ready_w !== 5'h1f && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("all_idle", 32'(in_ready_w), 32'h1f);
  endtask

  task automatic do_op(input logic [15:0] ai, input logic [15:0] bi, input logic si);
    logic [15:0] es;
    logic        ec, ev;
    bit          seen [NDUT];
    int          cyc, nseen;
    wait_all_ready();
    a = ai; b = bi; sub = si; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    for (int i = 0; i < NDUT; i++) seen[i] = 1'b0;
    nseen = 0;
    cyc = 0;
    while (nseen < NDUT && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < NDUT; i++) begin
        if (!seen[i] && out_valid_w[i]) begin
          seen[i] = 1'b1;
          nseen++;
          lat[i] = cyc;
          cap_sum[i] = get_sum(i);
          cap_c[i] = carry_w[i];
          cap_v[i] = ovf_w[i];
          ref_model(dut_w(i), ai, bi, si, es, ec, ev);
          chk($sformatf("sum[%0d]", i), 32'(cap_sum[i]), 32'(es));
          chk($sformatf("carry[%0d]", i), 32'(cap_c[i]), 32'(ec));
          chk($sformatf("ovf[%0d]", i), 32'(cap_v[i]), 32'(ev));
          chk($sformatf("latency[%0d]", i), 32'(cyc), 32'(dut_n(i)));
        end
      end
    end
    chk("results_seen", 32'(nseen), 32'(NDUT));
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hffff;
      2: return 16'h8080;
      3: return 16'h7f7f;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_in_ready", 32'(in_ready_w), 32'h1f);
    chk("rst_out_valid", 32'(out_valid_w), 32'h0);
    chk("rst_sum", 32'(sum8[0]), 32'h0);
    chk("rst_carry", 32'(carry_w), 32'h0);
    chk("rst_ovf", 32'(ovf_w), 32'h0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'd200, 16'd100, 1'b0);
    chk("tp_add_sum", 32'(cap_sum[0]), 32'd44);
    chk("tp_add_carry", 32'(cap_c[0]), 32'd1);
    chk("tp_add_ovf", 32'(cap_v[0]), 32'd0);
    chk("tp_add_lat", 32'(lat[0]), 32'd2);

    do_op(16'd100, 16'd27, 1'b0);
    chk("tp_127_sum", 32'(cap_sum[0]), 32'd127);
    chk("tp_127_ovf", 32'(cap_v[0]), 32'd0);

    do_op(16'd100, 16'd28, 1'b0);
    chk("tp_128_sum", 32'(cap_sum[0]), 32'd128);
    chk("tp_128_ovf", 32'(cap_v[0]), 32'd1);
    chk("tp_128_carry", 32'(cap_c[0]), 32'd0);

    do_op(16'd5, 16'd7, 1'b1);
    chk("tp_sub_sum", 32'(cap_sum[0]), 32'd254);
    chk("tp_sub_carry", 32'(cap_c[0]), 32'd0);
    chk("tp_sub_ovf", 32'(cap_v[0]), 32'd0);

    do_op(16'h0080, 16'h0001, 1'b1);
    chk("tp_subov_sum", 32'(cap_sum[0]), 32'h7f);
    chk("tp_subov_carry", 32'(cap_c[0]), 32'd1);
    chk("tp_subov_ovf", 32'(cap_v[0]), 32'd1);

    // Backpressure: 150 + 60 = 210 held while out_ready is low.
    begin
      int k;
      wait_all_ready();
      out_ready = 1'b0;
      a = 16'd150; b = 16'd60; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); sub = 1'b1;
      k = 0;
      while (!out_valid_w[0] && k < 10) begin
        @(posedge clk); #1;
        k++;
      end
      chk("bp_valid", 32'(out_valid_w[0]), 32'd1);
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        chk("bp_hold_valid", 32'(out_valid_w[0]), 32'd1);
        chk("bp_hold_ready", 32'(in_ready_w[0]), 32'd0);
        chk("bp_hold_sum", 32'(sum8[0]), 32'd210);
        chk("bp_hold_carry", 32'(carry_w[0]), 32'd0);
        chk("bp_hold_ovf", 32'(ovf_w[0]), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", 32'(out_valid_w[0]), 32'd0);
      chk("bp_release_ready", 32'(in_ready_w[0]), 32'd1);
    end

    // Asynchronous reset in the middle of BUSY.
    wait_all_ready();
    a = 16'd200; b = 16'd100; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready_w), 32'h1f);
    chk("arst_out_valid", 32'(out_valid_w), 32'h0);
    chk("arst_sum", 32'(sum8[0]), 32'h0);
    chk("arst_sum16", 32'(sum16), 32'h0);
    chk("arst_carry", 32'(carry_w), 32'h0);
    chk("arst_ovf", 32'(ovf_w), 32'h0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("arst_no_valid", 32'(out_valid_w), 32'h0);
      chk("arst_ready", 32'(in_ready_w), 32'h1f);
    end

    for (int n = 0; n < 2000; n++) begin
      do_op(pick_operand(), pick_operand(), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_nbit_seq.md
Name: adder_nbit_seq

Overview:
Parametrised multi-cycle adder/subtractor, the successor to the fixed 8-bit combinational adder. It processes CHUNK bits per clock and ripples the carry between chunks in a register. Valid/ready handshakes on both input and output let it sit between pipelined datapath stages and trade latency for a short carry chain.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
CHUNK, 4, bits added per cycle; must divide WIDTH (elaboration error otherwise); NCHUNK = WIDTH/CHUNK

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A (unsigned/two's complement)
b  input  WIDTH  operand B
sub  input  1  0: a+b, 1: a-b; sampled with operands
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
carry  output  1  carry out of MSB (sub: 1 = no borrow)
overflow  output  1  signed overflow

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). Reset drives state to IDLE and sets in_ready=1, out_valid=0, sum=0, carry=0, overflow=0. All internal operand, carry and index registers clear to 0.
- FSM states are IDLE, BUSY and DONE.
- IDLE: in_ready=1, out_valid=0.
  - Accept occurs when in_valid && in_ready on an edge.
  - On accept, latch opA=a and opB = sub ? ~b : b. Set carry register cin=sub and chunk index idx=0, then go to BUSY.
- BUSY: in_ready=0, out_valid=0.
  - Each edge computes {c, s} = opA[idx] + opB[idx] + cin over CHUNK bits, starting at the LSB chunk.
  - s is written into the result register at chunk idx. cin takes c and idx increments.
  - When the edge processes idx = NCHUNK-1, go to DONE. carry takes the final c. overflow = (opA MSB == opB MSB) && (sum MSB != opA MSB).
- Latency: if accept happens at edge k, out_valid rises after edge k+NCHUNK. With CHUNK=WIDTH the latency is 1.
- DONE: out_valid=1, in_ready=0.
  - sum, carry and overflow are held stable until out_ready=1 on an edge.
  - On that edge go to IDLE. A new operand is not accepted on the same edge; throughput is one op per NCHUNK+2 cycles.
- Outputs are registered only. sum, carry and overflow keep their last values in IDLE and BUSY. Their values are meaningful only while out_valid=1.
- Inputs a, b and sub are ignored outside the accept edge. Changing them during BUSY has no effect.
- in_valid may drop without penalty while in_ready=0. No combinational path from in_valid or out_ready to any output.
- Wrap-around: sum is modulo 2^WIDTH. For subtract, carry=1 when a>=b unsigned.
- Reset asserted mid-operation: immediate abort to the reset values. The operation is lost and no out_valid is produced.
- out_ready held high in IDLE or BUSY has no effect.

Decomposition:
- Package adder_pkg holds the state enum typedef (IDLE, BUSY, DONE) and a localparam function computing NCHUNK and the index width, $clog2(NCHUNK) with a minimum of 1.
- One sub-module, adder_chunk: combinational CHUNK-bit adder with inputs x, y, ci and outputs s, co. It is instantiated once and muxed by idx.
- FSM, operand and result registers stay in adder_nbit_seq.

Test Plan:
- WIDTH=8, CHUNK=4: a=200, b=100, sub=0 -> out_valid 2 cycles after accept; sum=44, carry=1, overflow=0.
- a=100, b=27 -> sum=127, overflow=0. Then a=100, b=28 -> sum=128, overflow=1, carry=0.
- sub=1, a=5, b=7 -> sum=254, carry=0, overflow=0. Then a=0x80, b=1 -> sum=0x7F, carry=1, overflow=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> sum/carry/overflow stable and in_ready=0. Then out_ready=1 for one edge -> out_valid=0 and in_ready=1 on the next cycle. Operands changed during BUSY do not alter the result.
- Reset: assert rst_n=0 asynchronously between clock edges during BUSY -> all outputs are at reset values immediately; after release in_ready=1 and no spurious out_valid.
- Parameter sweep for WIDTH=8 with CHUNK in {1, 2, 8}, and WIDTH=16 with CHUNK=4: exhaustive (8-bit) or 10k random (16-bit) operands for both add and sub, compared against a reference model. Latency must equal NCHUNK in every case.
